// File: rtl/wb_bus_ctrl.sv
// wb_bus_ctrl: single-master Wishbone controller routing one CPU master to bootrom/RAM/UART with a single error owner
//   clk, reset (sync, active-low)
//   i_wb_cyc/i_wb_stb/i_wb_we/i_wb_addr          master request
//   o_wb_data/o_wb_ack/o_wb_stall/o_wb_err       master response
//   o_fault_addr                                 address of the most recent errored access
//   o_slv_cyc/o_slv_stb, i_slv_ack/i_slv_stall/i_slv_data   slaves: bit0 bootrom, bit1 RAM, bit2 UART
//   WB_BUS_CTRL_TIMEOUT_EN: compiles in the ACTIVE-state timeout counter and its error path
module wb_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_wb_err,
  output logic [31:0] o_fault_addr,
  output logic [2:0]  o_slv_cyc,
  output logic [2:0]  o_slv_stb,
  input  logic [2:0]  i_slv_ack,
  input  logic [2:0]  i_slv_stall,
  input  logic [95:0] i_slv_data
);
  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_e;
  state_e state_q, state_d;
  logic [2:0] sel, sel_q, sel_d;
  logic [31:0] fault_q, fault_d, rd;
  logic mapped, sel_stall, ack;
`ifdef WB_BUS_CTRL_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT != 0;
`endif
  assign sel = {i_wb_addr[31:16] == 16'hc000, i_wb_addr[31:15] == 17'h16001, i_wb_addr[31:15] == 17'h16000};
  // bootrom is read-only, so a write to it is routed to the error path like a hole in the map
  assign mapped = |sel && !(sel[0] && i_wb_we);
  assign sel_stall = |(i_slv_stall & sel);
  // sel_q is one-hot, so only the latched slave can ever produce ack or data
  assign ack = |(i_slv_ack & sel_q);
  assign rd = ({32{sel_q[0]}} & i_slv_data[31:0]) | ({32{sel_q[1]}} & i_slv_data[63:32]) |
              ({32{sel_q[2]}} & i_slv_data[95:64]);
  assign o_fault_addr = fault_q;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    fault_d = fault_q;
    o_wb_data = '0;
    o_wb_ack = 1'b0;
    o_wb_stall = 1'b0;
    o_wb_err = 1'b0;
    o_slv_cyc = '0;
    o_slv_stb = '0;
`ifdef WB_BUS_CTRL_TIMEOUT_EN
    cnt_d = cnt_q;
    addr_d = addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          if (mapped) begin
            o_slv_cyc = sel;
            o_slv_stb = sel;
            o_wb_stall = sel_stall;
            if (!sel_stall) begin
              sel_d = sel;
              state_d = ACTIVE;
`ifdef WB_BUS_CTRL_TIMEOUT_EN
              cnt_d = '0;
              addr_d = i_wb_addr;
`endif
            end
          end else begin
            fault_d = i_wb_addr;
            state_d = ERROR;
          end
        end
      end
      ACTIVE: begin
        o_wb_stall = 1'b1;
        // a master that drops cyc aborts: slave cyc and any ack are suppressed that same cycle
        o_slv_cyc = i_wb_cyc ? sel_q : 3'b000;
        o_wb_ack = i_wb_cyc && ack;
        o_wb_data = (i_wb_cyc && ack) ? rd : '0;
        if (!i_wb_cyc || ack) state_d = IDLE;
`ifdef WB_BUS_CTRL_TIMEOUT_EN
        else if ({1'b0, cnt_q} + 17'd1 == 17'(TIMEOUT)) begin
          fault_d = addr_q;
          state_d = ERROR;
        end else cnt_d = cnt_q + 16'd1;
`endif
      end
      ERROR: begin
        o_wb_err = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q <= '0;
      fault_q <= '0;
`ifdef WB_BUS_CTRL_TIMEOUT_EN
      cnt_q <= '0;
      addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      fault_q <= fault_d;
`ifdef WB_BUS_CTRL_TIMEOUT_EN
      cnt_q <= cnt_d;
      addr_q <= addr_d;
`endif
    end
  end
endmodule

// File: tb/tb_wb_bus_ctrl.sv
// tb_wb_bus_ctrl: vector table plus response scoreboard for wb_bus_ctrl
module tb_wb_bus_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0] i_wb_addr, o_wb_data, o_fault_addr;
  logic o_wb_ack, o_wb_stall, o_wb_err;
  logic [2:0] o_slv_cyc, o_slv_stb, i_slv_ack, i_slv_stall;
  logic [95:0] i_slv_data;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [31:0] addr;
    logic we;
    int stalls;
    int delay;
    logic [2:0] sel;
  } vec_t;
  typedef struct {
    logic err;
    logic [31:0] val;
  } exp_t;
  vec_t vt[11];
  exp_t sb[$];
  exp_t me;
  wb_bus_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_err(o_wb_err),
    .o_fault_addr(o_fault_addr), .o_slv_cyc(o_slv_cyc), .o_slv_stb(o_slv_stb),
    .i_slv_ack(i_slv_ack), .i_slv_stall(i_slv_stall), .i_slv_data(i_slv_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (reset && (o_wb_ack || o_wb_err)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got ack=%0b err=%0b want none at %0t", o_wb_ack, o_wb_err, $time);
      end else begin
        me = sb.pop_front();
        chk("rsp_err", 32'(o_wb_err), 32'(me.err));
        if (me.err) chk("fault_addr", o_fault_addr, me.val);
        else chk("rdata", o_wb_data, me.val);
      end
    end
  end
  task automatic push(input logic err, input logic [31:0] val);
    exp_t e;
    e.err = err;
    e.val = val;
    sb.push_back(e);
  endtask
  task automatic req_accept(input logic [31:0] addr, input logic we);
    @(posedge clk); #1;
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we = we;
    i_wb_addr = addr;
    i_slv_stall = 3'b000;
    @(posedge clk); #1;
    i_wb_stb = 1'b0;
  endtask
  task automatic run(input vec_t v, input int idx);
    logic [31:0] s0, s1, s2;
    s0 = 32'h1000_0000 + 32'(idx);
    s1 = 32'h2000_0000 + (32'(idx) << 8);
    s2 = 32'h3000_0000 + (32'(idx) << 16);
    @(posedge clk); #1;
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we = v.we;
    i_wb_addr = v.addr;
    i_slv_data = {s2, s1, s0};
    i_slv_stall = v.stalls > 0 ? 3'b111 : 3'b000;
    for (int c = 0; c <= v.stalls; c++) begin
      @(negedge clk);
      chk("req_stb", 32'(o_slv_stb), 32'(v.sel));
      chk("req_stall", 32'(o_wb_stall), 32'(c < v.stalls));
      if (c == v.stalls) push(v.sel == 3'b000, v.sel == 3'b000 ? v.addr : v.sel[2] ? s2 : v.sel[1] ? s1 : s0);
      @(posedge clk); #1;
      i_slv_stall = (c + 1 < v.stalls) ? 3'b111 : 3'b000;
    end
    i_wb_stb = 1'b0;
    if (v.sel == 3'b000) begin
      i_wb_cyc = 1'b0;
      @(negedge clk);
      chk("err_nocyc", 32'(o_slv_cyc), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_one_cycle", 32'(o_wb_err), 32'd0);
    end else begin
      for (int d = 0; d < v.delay; d++) begin
        @(negedge clk);
        chk("act_cyc", 32'(o_slv_cyc), 32'(v.sel));
        chk("act_stb", 32'(o_slv_stb), 32'd0);
        chk("act_stall", 32'(o_wb_stall), 32'd1);
        chk("act_noack", 32'(o_wb_ack), 32'd0);
        @(posedge clk); #1;
      end
      i_slv_ack = v.sel;
      @(negedge clk);
      @(posedge clk); #1;
      i_slv_ack = 3'b000;
      i_wb_cyc = 1'b0;
    end
  endtask
  initial begin
    vt[0]  = '{32'hb000_0010, 1'b0, 0, 0, 3'b001};
    vt[1]  = '{32'hb000_8004, 1'b1, 3, 0, 3'b010};
    vt[2]  = '{32'ha000_0000, 1'b0, 0, 0, 3'b000};
    vt[3]  = '{32'hb000_0000, 1'b1, 0, 0, 3'b000};
    vt[4]  = '{32'hc000_0000, 1'b0, 1, 2, 3'b100};
    vt[5]  = '{32'hb000_7ffc, 1'b0, 0, 1, 3'b001};
    vt[6]  = '{32'hb000_ffff, 1'b0, 0, 0, 3'b010};
    vt[7]  = '{32'hb001_0000, 1'b0, 0, 0, 3'b000};
    vt[8]  = '{32'hc000_ffff, 1'b1, 2, 1, 3'b100};
    vt[9]  = '{32'hc001_0000, 1'b1, 0, 0, 3'b000};
    vt[10] = '{32'hb000_8000, 1'b1, 0, 3, 3'b010};
    reset = 1'b0;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we = 1'b0;
    i_wb_addr = '0;
    i_slv_ack = '0;
    i_slv_stall = '0;
    i_slv_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(o_slv_cyc), 32'd0);
    chk("rst_stb", 32'(o_slv_stb), 32'd0);
    chk("rst_ack_err_stall", 32'({o_wb_ack, o_wb_err, o_wb_stall}), 32'd0);
    chk("rst_data", o_wb_data, 32'd0);
    chk("rst_fault", o_fault_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 11; i++) run(vt[i], i);
    // UART never acks: timeout error (if compiled in), late ack must be ignored
    i_slv_data = {32'h3333_aaaa, 32'h2222_aaaa, 32'h1111_aaaa};
    req_accept(32'hc000_0000, 1'b0);
`ifdef WB_BUS_CTRL_TIMEOUT_EN
    push(1'b1, 32'hc000_0000);
`endif
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
`ifdef WB_BUS_CTRL_TIMEOUT_EN
      chk("timeout_err", 32'(o_wb_err), 32'(k == 9));
`else
      chk("timeout_err", 32'(o_wb_err), 32'd0);
`endif
      @(posedge clk); #1;
    end
`ifdef WB_BUS_CTRL_TIMEOUT_EN
    i_slv_ack = 3'b100;
    @(negedge clk);
    chk("late_ack", 32'(o_wb_ack), 32'd0);
    @(posedge clk); #1;
    i_slv_ack = 3'b000;
    i_wb_cyc = 1'b0;
`else
    chk("wait_cyc", 32'(o_slv_cyc), 32'b100);
    i_wb_cyc = 1'b0;
    @(negedge clk);
    chk("drop_cyc", 32'(o_slv_cyc), 32'd0);
`endif
    // master drops cyc in ACTIVE while the slave acks: nothing forwarded
    req_accept(32'hc000_0040, 1'b0);
    i_wb_cyc = 1'b0;
    i_slv_ack = 3'b100;
    @(negedge clk);
    chk("abort_ack", 32'(o_wb_ack), 32'd0);
    chk("abort_cyc", 32'(o_slv_cyc), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle_ack", 32'(o_wb_ack), 32'd0);
    @(posedge clk); #1;
    i_slv_ack = 3'b000;
    // spurious ack from a non-latched slave
    req_accept(32'hb000_8008, 1'b0);
    push(1'b0, 32'h2222_aaaa);
    i_slv_ack = 3'b100;
    @(negedge clk);
    chk("spurious_ack", 32'(o_wb_ack), 32'd0);
    @(posedge clk); #1;
    i_slv_ack = 3'b010;
    @(negedge clk);
    chk("real_ack", 32'(o_wb_ack), 32'd1);
    @(posedge clk); #1;
    i_slv_ack = 3'b000;
    i_wb_cyc = 1'b0;
    // reset in the middle of an ACTIVE transfer
    req_accept(32'hb000_8010, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    i_slv_ack = 3'b010;
    @(negedge clk);
    chk("rstmid_cyc", 32'(o_slv_cyc), 32'd0);
    chk("rstmid_ack", 32'(o_wb_ack), 32'd0);
    chk("rstmid_stall", 32'(o_wb_stall), 32'd0);
    chk("rstmid_fault", o_fault_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    i_slv_ack = 3'b000;
    i_wb_cyc = 1'b0;
    run(vt[6], 20);
    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_bus_ctrl.md
# wb_bus_ctrl

Single-master Wishbone bus controller between the CPU core and the SoC slaves (bootrom, internal RAM, UART). It decodes the master address and routes cyc/stb to exactly one slave. It multiplexes that slave's ack/stall/data back to the master. It raises a one-cycle bus error for unmapped accesses, bootrom writes and (optionally) timeouts, replacing the shared, multiply-driven response wires with one owner.

## Interface
- TIMEOUT, 255: cycles in ACTIVE without ack before an error is raised (1..65535)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- i_wb_cyc  in  1  master cycle
- i_wb_stb  in  1  master strobe
- i_wb_we  in  1  master write enable
- i_wb_addr  in  32  master byte address
- o_wb_data  out  32  read data from selected slave
- o_wb_ack  out  1  transfer acknowledge to master
- o_wb_stall  out  1  stall to master
- o_wb_err  out  1  bus error pulse to master (feeds CPU i_exception)
- o_fault_addr  out  32  address of the most recent errored access
- o_slv_cyc  out  3  per-slave cycle; bit0 bootrom, bit1 RAM, bit2 UART
- o_slv_stb  out  3  per-slave strobe
- i_slv_ack  in  3  per-slave ack
- i_slv_stall  in  3  per-slave stall
- i_slv_data  in  96  per-slave read data, slave n at [32n+31:32n]

## Operation
- Address map: 0xb000_0000–0xb000_7fff → slave 0; 0xb000_8000–0xb000_ffff → slave 1; 0xc000_0000–0xc000_ffff → slave 2; all else unmapped.
- Write (i_wb_we=1) to slave 0 is treated as unmapped.
- States: IDLE, ACTIVE, ERROR. Reset → IDLE.
- IDLE, i_wb_cyc&i_wb_stb, mapped: o_slv_cyc/o_slv_stb bit of decoded slave = 1 combinationally; o_wb_stall = i_slv_stall of that slave. Accept when stall=0: latch slave index, clear timeout counter → ACTIVE.
- IDLE, request unmapped: o_wb_stall=0, no slave strobed, latch i_wb_addr into o_fault_addr → ERROR.
- ACTIVE: o_slv_cyc of latched slave held 1, o_slv_stb=0, o_wb_stall=1. o_wb_ack = i_slv_ack[latched]; o_wb_data = latched slave data when ack, else 0. On ack → IDLE.
- ERROR: o_wb_err=1 for exactly one cycle → IDLE.
- i_wb_cyc low in ACTIVE: abort → IDLE, no ack/err forwarded.
- Acks arriving in IDLE or from non-latched slaves are ignored.
- Single outstanding transaction; no pipelining.

## Timing
- Reset values: all outputs 0, o_fault_addr=0, counter=0.
- Decode and strobe forwarding: 0 cycles (combinational from master inputs, gated by state==IDLE).
- Minimum transfer: accept at edge N, slave ack in cycle N+1 → o_wb_ack in cycle N+1 (ack combinationally passed); next request accepted in cycle N+2.
- Unmapped: accept at edge N, o_wb_err high during cycle N+1 only.
- Timeout counter increments each ACTIVE cycle. When it reaches TIMEOUT with no ack, the latched address goes to o_fault_addr, state → ERROR, and cyc is dropped. A slave ack in that same cycle wins (ack, no error).
- Reset asserted mid-transaction: next edge forces IDLE, all strobes/cyc low, pending transfer discarded.

## Configuration
- WB_BUS_CTRL_TIMEOUT_EN defined: timeout counter and timeout error path compiled in as above.
- Undefined: no counter; ACTIVE waits indefinitely for ack or cyc drop. TIMEOUT parameter unused. Unmapped/bootrom-write errors still generated.

## Test plan
- Read 0xb000_0010, slave 0 acks next cycle with 0xdeadbeef → o_wb_ack 1 cycle, o_wb_data=0xdeadbeef, o_slv_stb=3'b001 only during accept.
- Write 0xb000_8004, slave 1 stalls 3 cycles then acks → o_wb_stall high 3 cycles, o_slv_stb bit1 held, single ack, no err.
- Read 0xa000_0000 → no slave strobed, o_wb_err 1 cycle, o_fault_addr=0xa000_0000; write 0xb000_0000 → same with 0xb000_0000.
- Read 0xc000_0000, UART never acks, TIMEOUT=8, macro defined → o_wb_err at 9th cycle after accept, o_fault_addr=0xc000_0000; late ack ignored; macro undefined → no err.
- Reset low during ACTIVE → next cycle o_slv_cyc=0, outputs 0, subsequent read to RAM completes normally.
- Spurious i_slv_ack[2] while transfer latched to slave 1 → no o_wb_ack until i_slv_ack[1].
